// File: rtl/icache_refill_pkg.sv
// Shared address-split constants and refill FSM types for the instruction cache.
// The cache and its refill controller import this package so their address split always agrees.
package icache_refill_pkg;

   localparam int unsigned VIRT_ADDR_WIDTH         = 32;
   localparam int unsigned ICACHE_LINE_WIDTH       = 128;
   localparam int unsigned ICACHE_INDEX_WIDTH      = 6;
   localparam int unsigned ICACHE_BYTEINLINE_WIDTH = 4;
   localparam int unsigned ICACHE_TAG_WIDTH        =
      VIRT_ADDR_WIDTH - ICACHE_INDEX_WIDTH - ICACHE_BYTEINLINE_WIDTH;

   localparam int unsigned MEM_BEAT_WIDTH = 32;

   typedef enum logic [1:0] {
      StIdle,
      StReq,
      StBeats,
      StWrite
   } refill_state_e;

   function automatic int unsigned beats_per_line(input int unsigned line_w,
                                                  input int unsigned beat_w);
      return line_w / beat_w;
   endfunction

   // Counter width that stays legal when a line is a single beat.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/icache_line_asm.sv
// Assembles memory read beats into one cache line, lowest address in slot 0.
// o_last flags the beat that completes the line.
module icache_line_asm
   import icache_refill_pkg::*;
#(
   parameter int unsigned LINE_W = ICACHE_LINE_WIDTH,
   parameter int unsigned BEAT_W = MEM_BEAT_WIDTH
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_clear,
   input  logic              i_beat_valid,
   input  logic [BEAT_W-1:0] i_beat_data,
   output logic              o_last,
   output logic [LINE_W-1:0] o_line
);

   localparam int unsigned NumBeats = beats_per_line(LINE_W, BEAT_W);
   localparam int unsigned CntW     = cnt_width(NumBeats);
   localparam logic [CntW-1:0] LastCnt = CntW'(NumBeats - 1);

   logic [CntW-1:0]   r_cnt;
   logic [LINE_W-1:0] r_line;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_cnt <= '0;
      end else if (i_clear) begin
         r_cnt <= '0;
      end else if (i_beat_valid) begin
         r_cnt <= (r_cnt == LastCnt) ? '0 : r_cnt + CntW'(1);
      end
   end

   // Data path is not reset; contents only matter once a full line is in.
   always_ff @(posedge i_clk) begin
      if (i_beat_valid) begin
         for (int unsigned k = 0; k < NumBeats; k++) begin
            if (r_cnt == CntW'(k)) begin
               r_line[k*BEAT_W +: BEAT_W] <= i_beat_data;
            end
         end
      end
   end

   assign o_last = i_beat_valid && (r_cnt == LastCnt);
   assign o_line = r_line;

endmodule

// File: rtl/icache_refill.sv
// Instruction-cache miss handler: stalls fetch, reads the missing line from memory,
// and writes the assembled line with its index and tag into the cache fill port.
module icache_refill
   import icache_refill_pkg::*;
#(
   parameter int unsigned ADDR_W  = VIRT_ADDR_WIDTH,
   parameter int unsigned LINE_W  = ICACHE_LINE_WIDTH,
   parameter int unsigned BEAT_W  = MEM_BEAT_WIDTH,
   parameter int unsigned INDEX_W = ICACHE_INDEX_WIDTH,
   parameter int unsigned OFFS_W  = ICACHE_BYTEINLINE_WIDTH
) (
   input  logic                         i_clk,
   input  logic                         i_reset,
   input  logic                         i_miss,
   input  logic [ADDR_W-1:0]            i_miss_addr,
   output logic                         o_stall,
   output logic                         o_mem_req,
   output logic [ADDR_W-1:0]            o_mem_addr,
   input  logic                         i_mem_gnt,
   input  logic                         i_mem_rvalid,
   input  logic [BEAT_W-1:0]            i_mem_rdata,
   input  logic                         i_mem_err,
   output logic                         o_fill_en,
   output logic [INDEX_W-1:0]           o_fill_index,
   output logic [ADDR_W-INDEX_W-OFFS_W-1:0] o_fill_tag,
   output logic [LINE_W-1:0]            o_fill_data,
   output logic                         o_refill_err
);

   localparam int unsigned TAG_W = ADDR_W - INDEX_W - OFFS_W;
   localparam logic [ADDR_W-1:0] LineMask = {{(ADDR_W-OFFS_W){1'b1}}, {OFFS_W{1'b0}}};

   refill_state_e r_state;
   refill_state_e w_state_d;

   logic [ADDR_W-1:0] r_addr;
   logic              r_mem_req;
   logic              r_fill_en;
   logic              r_refill_err;

   logic              w_latch;
   logic              w_clear;
   logic              w_beat_valid;
   logic              w_last;
   logic              w_err_abort;
   logic [LINE_W-1:0] w_line;

   // Beats only count in BEATS; strays in other states never touch the buffer.
   assign w_beat_valid = (r_state == StBeats) && i_mem_rvalid;
   assign w_clear      = (r_state == StReq) && i_mem_gnt && !i_mem_err;

   icache_line_asm #(
      .LINE_W (LINE_W),
      .BEAT_W (BEAT_W)
   ) u_line_asm (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_clear      (w_clear),
      .i_beat_valid (w_beat_valid),
      .i_beat_data  (i_mem_rdata),
      .o_last       (w_last),
      .o_line       (w_line)
   );

   always_comb begin
      w_state_d   = r_state;
      w_latch     = 1'b0;
      w_err_abort = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (i_miss) begin
               w_latch   = 1'b1;
               w_state_d = StReq;
            end
         end
         StReq: begin
            if (i_mem_err) begin
               w_err_abort = 1'b1;
               w_state_d   = StIdle;
            end else if (i_mem_gnt) begin
               w_state_d = StBeats;
            end
         end
         StBeats: begin
            if (i_mem_err) begin
               w_err_abort = 1'b1;
               w_state_d   = StIdle;
            end else if (w_last) begin
               w_state_d = StWrite;
            end
         end
         StWrite: begin
            w_state_d = StIdle;
         end
         default: begin
            w_state_d = StIdle;
         end
      endcase
   end

   // Strobes are derived from the next state so they line up with the state they belong to.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state      <= StIdle;
         r_mem_req    <= 1'b0;
         r_fill_en    <= 1'b0;
         r_refill_err <= 1'b0;
      end else begin
         r_state      <= w_state_d;
         r_mem_req    <= (w_state_d == StReq);
         r_fill_en    <= (w_state_d == StWrite);
         r_refill_err <= w_err_abort;
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_latch) begin
         r_addr <= i_miss_addr;
      end
   end

   assign o_stall      = (r_state == StIdle) ? i_miss : 1'b1;
   assign o_mem_req    = r_mem_req;
   assign o_mem_addr   = r_addr & LineMask;
   assign o_fill_en    = r_fill_en;
   assign o_fill_index = r_addr[OFFS_W +: INDEX_W];
   assign o_fill_tag   = r_addr[ADDR_W-1 -: TAG_W];
   assign o_fill_data  = w_line;
   assign o_refill_err = r_refill_err;

endmodule

// File: tb/tb_icache_refill.sv
// Directed bench for icache_refill: expected waveforms are derived from each scenario's
// miss/grant/beat/error timing, checked every cycle, plus literal spot checks per scenario.
module tb_icache_refill;

   localparam int NC = 24;

   logic         clk;
   logic         i_reset;
   logic         i_miss;
   logic [31:0]  i_miss_addr;
   logic         o_stall;
   logic         o_mem_req;
   logic [31:0]  o_mem_addr;
   logic         i_mem_gnt;
   logic         i_mem_rvalid;
   logic [31:0]  i_mem_rdata;
   logic         i_mem_err;
   logic         o_fill_en;
   logic [5:0]   o_fill_index;
   logic [21:0]  o_fill_tag;
   logic [127:0] o_fill_data;
   logic         o_refill_err;

   icache_refill dut (
      .i_clk        (clk),
      .i_reset      (i_reset),
      .i_miss       (i_miss),
      .i_miss_addr  (i_miss_addr),
      .o_stall      (o_stall),
      .o_mem_req    (o_mem_req),
      .o_mem_addr   (o_mem_addr),
      .i_mem_gnt    (i_mem_gnt),
      .i_mem_rvalid (i_mem_rvalid),
      .i_mem_rdata  (i_mem_rdata),
      .i_mem_err    (i_mem_err),
      .o_fill_en    (o_fill_en),
      .o_fill_index (o_fill_index),
      .o_fill_tag   (o_fill_tag),
      .o_fill_data  (o_fill_data),
      .o_refill_err (o_refill_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Per-cycle stimulus and expectations for the current scenario.
   logic        s_miss [NC];
   logic [31:0] s_addr [NC];
   logic        s_gnt  [NC];
   logic        s_rv   [NC];
   logic [31:0] s_data [NC];
   logic        s_err  [NC];
   logic        s_rst  [NC];
   logic        e_stall[NC];
   logic        e_req  [NC];
   logic        e_fill [NC];
   logic        e_rerr [NC];
   logic [31:0]  e_maddr;
   logic [5:0]   e_idx;
   logic [21:0]  e_tag;
   logic [127:0] e_line;

   int n_tests;
   int n_fail;
   int cyc;
   logic active;

   int           obs_req_cnt;
   int           obs_fill_cyc;
   int           obs_rerr_cyc;
   int           obs_last_stall;
   logic [31:0]  obs_maddr;
   logic [5:0]   obs_idx;
   logic [21:0]  obs_tag;
   logic [127:0] obs_data;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
      end
   endtask

   // Expected behaviour follows from the timing rules: request from the cycle after the miss
   // until grant, line written the cycle after the last beat, error pulse the cycle after
   // the error, and stall from the miss until the refill (or abort/reset) cycle.
   task automatic plan(input int t, input logic [31:0] addr, input int g,
                       input int b0, input int b1, input int b2, input int b3,
                       input int e, input int r,
                       input logic [31:0] d0, input logic [31:0] d1,
                       input logic [31:0] d2, input logic [31:0] d3);
      int b[4];
      logic [31:0] d[4];
      int endc;
      int req_end;
      b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3;
      d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
      for (int c = 0; c < NC; c++) begin
         s_miss[c] = 1'b0; s_addr[c] = addr; s_gnt[c] = 1'b0; s_rv[c] = 1'b0;
         s_data[c] = 32'h0; s_err[c] = 1'b0; s_rst[c] = 1'b0;
         e_stall[c] = 1'b0; e_req[c] = 1'b0; e_fill[c] = 1'b0; e_rerr[c] = 1'b0;
      end
      s_miss[t] = 1'b1;
      s_gnt[g]  = 1'b1;
      if (e >= 0) s_err[e] = 1'b1;
      if (r >= 0) s_rst[r] = 1'b1;
      for (int k = 0; k < 4; k++) begin
         if (b[k] >= 0 && (r < 0 || b[k] < r) && (e < 0 || b[k] <= e)) begin
            s_rv[b[k]]   = 1'b1;
            s_data[b[k]] = d[k];
         end
      end
      if (e >= 0)      endc = e;
      else if (r >= 0) endc = r;
      else             endc = b[3] + 1;
      req_end = (g < endc) ? g : endc;
      for (int c = t; c <= endc; c++) e_stall[c] = 1'b1;
      for (int c = t + 1; c <= req_end; c++) e_req[c] = 1'b1;
      if (e < 0 && r < 0) e_fill[b[3] + 1] = 1'b1;
      if (e >= 0) e_rerr[e + 1] = 1'b1;
      e_maddr = addr & ~32'hF;
      e_idx   = addr[9:4];
      e_tag   = addr[31:10];
      e_line  = {d[3], d[2], d[1], d[0]};
      obs_req_cnt = 0; obs_fill_cyc = -1; obs_rerr_cyc = -1; obs_last_stall = -1;
      obs_maddr = '0; obs_idx = '0; obs_tag = '0; obs_data = '0;
   endtask

   task automatic run(input int len);
      for (int c = 0; c < len; c++) begin
         i_reset      = s_rst[c];
         i_miss       = s_miss[c];
         i_miss_addr  = s_addr[c];
         i_mem_gnt    = s_gnt[c];
         i_mem_rvalid = s_rv[c];
         i_mem_rdata  = s_data[c];
         i_mem_err    = s_err[c];
         cyc          = c;
         active       = 1'b1;
         @(posedge clk);
         #1;
      end
      active = 1'b0;
   endtask

   always @(negedge clk) begin
      if (active) begin
         chk("stall", o_stall, e_stall[cyc]);
         chk("mem_req", o_mem_req, e_req[cyc]);
         chk("fill_en", o_fill_en, e_fill[cyc]);
         chk("refill_err", o_refill_err, e_rerr[cyc]);
         if (e_req[cyc]) chk("mem_addr", o_mem_addr, e_maddr);
         if (e_fill[cyc]) begin
            chk("fill_index", o_fill_index, e_idx);
            chk("fill_tag", o_fill_tag, e_tag);
            chk("fill_data", o_fill_data, e_line);
         end
         if (o_mem_req) begin
            obs_req_cnt++;
            obs_maddr = o_mem_addr;
         end
         if (o_fill_en) begin
            obs_fill_cyc = cyc;
            obs_idx  = o_fill_index;
            obs_tag  = o_fill_tag;
            obs_data = o_fill_data;
         end
         if (o_refill_err) obs_rerr_cyc = cyc;
         if (o_stall) obs_last_stall = cyc;
      end
   end

   initial begin
      n_tests = 0; n_fail = 0; cyc = 0; active = 1'b0;
      i_reset = 1'b1; i_miss = 1'b0; i_miss_addr = '0; i_mem_gnt = 1'b0;
      i_mem_rvalid = 1'b0; i_mem_rdata = '0; i_mem_err = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_stall", o_stall, 1'b0);
      chk("reset_mem_req", o_mem_req, 1'b0);
      chk("reset_fill_en", o_fill_en, 1'b0);
      chk("reset_refill_err", o_refill_err, 1'b0);

      // Best case: miss at T=1, grant at T+1, beats T+2..T+5.
      plan(1, 32'h0000_0053, 2, 3, 4, 5, 6, -1, -1,
           32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
      run(10);
      chk("s1_mem_addr", obs_maddr, 32'h0000_0050);
      chk("s1_fill_cycle", obs_fill_cyc, 7);
      chk("s1_last_stall_cycle", obs_last_stall, 7);
      chk("s1_fill_index", obs_idx, 6'h05);
      chk("s1_fill_tag", obs_tag, 22'h0);
      chk("s1_fill_data", obs_data, 128'h44444444_33333333_22222222_11111111);

      // Grant 3 cycles late, gap between beats 2 and 3, stray beat while requesting.
      plan(1, 32'h0000_0053, 5, 6, 7, 9, 10, -1, -1,
           32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
      s_rv[3] = 1'b1; s_data[3] = 32'hDEAD_BEEF;
      run(14);
      chk("s2_req_cycles", obs_req_cnt, 4);
      chk("s2_fill_cycle", obs_fill_cyc, 11);
      chk("s2_fill_data", obs_data, 128'h44444444_33333333_22222222_11111111);

      // Miss address changes mid-refill while miss stays high.
      plan(1, 32'h0000_0053, 2, 3, 4, 5, 6, -1, -1,
           32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
      for (int c = 3; c <= 6; c++) begin
         s_miss[c] = 1'b1;
         s_addr[c] = 32'hFFFF_FFC0;
      end
      run(12);
      chk("s3_req_cycles", obs_req_cnt, 1);
      chk("s3_fill_index", obs_idx, 6'h05);
      chk("s3_fill_tag", obs_tag, 22'h0);

      // Bus error on the second beat.
      plan(1, 32'h0000_0053, 2, 3, 4, 5, 6, 4, -1,
           32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
      run(9);
      chk("s4_refill_err_cycle", obs_rerr_cyc, 5);
      chk("s4_no_fill", obs_fill_cyc, -1);
      chk("s4_last_stall_cycle", obs_last_stall, 4);

      // Reset during the beat phase abandons the refill.
      plan(1, 32'h0000_0053, 2, 3, 4, 5, 6, -1, 4,
           32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
      run(9);
      chk("s5_no_fill", obs_fill_cyc, -1);
      chk("s5_last_stall_cycle", obs_last_stall, 4);

      // Fresh miss after the reset refills correctly.
      plan(1, 32'h1234_5678, 2, 3, 4, 5, 6, -1, -1,
           32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2, 32'hD3D3D3D3);
      run(10);
      chk("s6_mem_addr", obs_maddr, 32'h1234_5670);
      chk("s6_fill_index", obs_idx, 6'h27);
      chk("s6_fill_tag", obs_tag, 22'h48D15);
      chk("s6_fill_data", obs_data, 128'hD3D3D3D3_C2C2C2C2_B1B1B1B1_A0A0A0A0);

      // Error together with grant; a stray beat afterwards must not matter.
      plan(1, 32'h0000_0053, 2, -1, -1, -1, -1, 2, -1,
           32'h0, 32'h0, 32'h0, 32'h0);
      s_rv[3] = 1'b1; s_data[3] = 32'h5555_5555;
      run(8);
      chk("s7_refill_err_cycle", obs_rerr_cyc, 3);
      chk("s7_no_fill", obs_fill_cyc, -1);
      chk("s7_req_cycles", obs_req_cnt, 1);

      // Normal refill after the aborted one.
      plan(1, 32'h0000_03F4, 2, 3, 5, 6, 8, -1, -1,
           32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10);
      run(12);
      chk("s8_fill_cycle", obs_fill_cyc, 9);
      chk("s8_fill_index", obs_idx, 6'h3F);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/icache_refill.md
# icache_refill

Miss-handling controller that sits directly behind the instruction cache. When the cache reports a miss for the current fetch address, the controller stalls fetch and requests the enclosing line from instruction memory. It assembles the returned beats into a full line and writes that line, with its tag and index, into the cache's fill port. The next lookup then hits and fetch resumes.

## Interface
- `ADDR_W`, 32: virtual address width (matches `VIRT_ADDR_WIDTH`).
- `LINE_W`, 128: cache line width in bits (matches `ICACHE_LINE_WIDTH`).
- `BEAT_W`, 32: memory read-data width per beat; `LINE_W` must be a multiple of it.
- `INDEX_W`, 6: line index width (matches `ICACHE_INDEX_WIDTH`).
- `OFFS_W`, 4: byte-in-line width (matches `ICACHE_BYTEINLINE_WIDTH`).
- `clk`  in  1: single clock; all state updates on its rising edge.
- `reset`  in  1: synchronous, active-high.
- `miss`  in  1: cache lookup missed for `miss_addr`; sampled in IDLE only.
- `miss_addr`  in  ADDR_W: fetch address that missed.
- `stall`  out  1: fetch must hold its PC.
- `mem_req`  out  1: line read request; held until granted.
- `mem_addr`  out  ADDR_W: line-aligned request address (low `OFFS_W` bits zero).
- `mem_gnt`  in  1: request accepted.
- `mem_rvalid`  in  1: `mem_rdata` holds a valid beat.
- `mem_rdata`  in  BEAT_W: read beat, lowest address first.
- `mem_err`  in  1: bus error for the outstanding line.
- `fill_en`  out  1: one-cycle write strobe to the cache.
- `fill_index`  out  INDEX_W: line to write.
- `fill_tag`  out  ADDR_W-INDEX_W-OFFS_W: tag to store; the valid bit is set by the cache on `fill_en`.
- `fill_data`  out  LINE_W: assembled line.
- `refill_err`  out  1: one-cycle pulse on an aborted refill.

## Operation
- States: IDLE, REQ, BEATS, WRITE.
- IDLE
  - If `miss` is high: latch `miss_addr` into an internal address register and go to REQ.
  - Otherwise stay in IDLE.
- REQ
  - `mem_req`=1, with `mem_addr` = latched address with offset bits cleared.
  - On `mem_gnt`: clear the beat counter and go to BEATS.
  - `mem_rvalid` is ignored in REQ.
- BEATS
  - Each `mem_rvalid` writes `mem_rdata` into slot `beat_cnt` of the line buffer (slot k = bits [k*BEAT_W +: BEAT_W]) and increments `beat_cnt`.
  - On the last beat (`beat_cnt` = LINE_W/BEAT_W-1 with `mem_rvalid`), go to WRITE.
  - Gaps between beats are allowed.
- WRITE
  - `fill_en`=1 for exactly one cycle.
  - `fill_index` = latched addr[OFFS_W +: INDEX_W]; `fill_tag` = latched addr upper bits.
  - Go to IDLE.
- `stall` = (IDLE and `miss`) or any state other than IDLE. It is combinational on `miss` in IDLE, registered-state otherwise.
- `miss` and `miss_addr` are ignored outside IDLE; the latched address is the sole source until return to IDLE.
- `mem_err` in REQ or BEATS:
  - Pulse `refill_err` the next cycle.
  - Discard the buffer (no `fill_en`), return to IDLE, and drop `stall` unless `miss` is still high.
- `mem_err` in REQ takes priority over a simultaneous `mem_gnt`. In BEATS it takes priority over a simultaneous last beat.
- Extra `mem_rvalid` seen in IDLE or WRITE is ignored.
- Reset
  - Next state is IDLE.
  - `mem_req`, `fill_en`, `refill_err`, `stall`-from-state and `beat_cnt` all go to 0.
  - The line buffer and address register are not reset; outputs derived from them are don't-care while `fill_en`=0.
  - Reset mid-refill abandons the transfer without a fill.

## Timing
- Miss sampled at cycle T → REQ at T+1.
- `mem_gnt` at cycle G → BEATS at G+1.
- Last beat at cycle L → WRITE (`fill_en`) at L+1 → IDLE at L+2.
- Best case (gnt at T+1, beats back-to-back T+2..T+5): `fill_en` at T+6, `stall` high T..T+6, i.e. 7 cycles.
- `mem_req`, `mem_addr`, `fill_*` and `refill_err` are registered outputs.

## Structure
- Share address-split constants (`VIRT_ADDR_WIDTH`, `ICACHE_LINE_WIDTH`, `ICACHE_INDEX_WIDTH`, `ICACHE_BYTEINLINE_WIDTH`, `ICACHE_TAG_WIDTH`) with the cache through the common icache defines header.
- State encoding and beat count (LINE_W/BEAT_W) are local parameters.
- One natural sub-module: `icache_line_asm`, which holds the beat counter and slot-indexed line buffer, with `clear`, `beat_valid`, `beat_data`, `last` and `line`.

## Test plan
- Miss at 0x0000_0053, gnt same cycle as req, beats 0x11111111, 0x22222222, 0x33333333, 0x44444444 back-to-back:
  - `mem_addr`=0x0000_0050.
  - `fill_index`=0x05, `fill_tag`=0.
  - `fill_data`=0x44444444_33333333_22222222_11111111.
  - `fill_en` at T+6, `stall` low at T+7.
- gnt delayed 3 cycles and one idle cycle between beats 2 and 3: `mem_req` held 4 cycles, `fill_en` shifted by 4 cycles, same data.
- `miss_addr` changed to 0xFFFF_FFC0 during BEATS: the fill still uses index 0x05 / tag 0, and no second request is issued.
- `mem_err` on the 2nd beat: no `fill_en`, `refill_err` pulse one cycle later, state back to IDLE.
- `reset` asserted during BEATS: next cycle `mem_req`=0, `stall`=0 (with `miss` low), and no fill. A fresh miss afterwards refills correctly.
- `mem_err` together with `mem_gnt` in REQ: treated as an error, with no transition to BEATS.
